// File: rtl/pe_conv_lanes_pkg.sv
// rtl/pe_conv_lanes_pkg.sv - shared widths, op encodings and helpers for the lane converter
package pe_conv_lanes_pkg;

    localparam int dwidth_double = 64;
    localparam int DBL_BIAS      = 1023;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_I2D  = 2'b01,
        OP_NEG  = 2'b10,
        OP_ABS  = 2'b11
    } op_e;

    // Normalised magnitude: implicit leading one already dropped from frac.
    typedef struct packed {
        logic        sign;
        logic        zero;
        logic [10:0] exp;
        logic [62:0] frac;
    } i2d_norm_t;

    function automatic logic [5:0] clz64(input logic [63:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) n = 6'(63 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/pe_i2d_lane.sv
// rtl/pe_i2d_lane.sv - one 64-bit lane: pass/int64->double/negate/abs, LATENCY-stage enabled pipe
module pe_i2d_lane
    import pe_conv_lanes_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [dwidth_double-1:0] din,
    input  logic [1:0]               op,
    output logic [dwidth_double-1:0] dout
);

    localparam int TAIL = LATENCY - 3;

    logic [63:0] s1_data;
    logic [1:0]  s1_op;
    logic [63:0] s2_raw;
    logic [1:0]  s2_op;
    i2d_norm_t   s2_nrm;
    logic [63:0] s3_res;

    logic [63:0] mag;
    logic [5:0]  lz;
    logic [62:0] norm;
    i2d_norm_t   nrm_d;

    logic        guard;
    logic        sticky;
    logic        rnd;
    logic [52:0] mant_sum;
    logic [10:0] exp_r;
    logic [63:0] i2d;
    logic [63:0] res_d;

    always_comb begin
        mag         = s1_data[63] ? (~s1_data + 64'd1) : s1_data;
        lz          = clz64(mag);
        norm        = 63'(mag << lz);
        nrm_d.sign  = s1_data[63];
        nrm_d.zero  = (mag == 64'd0);
        nrm_d.exp   = 11'(DBL_BIAS + 63) - {5'd0, lz};
        nrm_d.frac  = norm;
    end

    // Round-to-nearest-even; a mantissa carry-out bumps the exponent and leaves mant zero.
    always_comb begin
        guard    = s2_nrm.frac[10];
        sticky   = |s2_nrm.frac[9:0];
        rnd      = guard & (sticky | s2_nrm.frac[11]);
        mant_sum = {1'b0, s2_nrm.frac[62:11]} + {52'd0, rnd};
        exp_r    = s2_nrm.exp + {10'd0, mant_sum[52]};
        i2d      = s2_nrm.zero ? 64'd0 : {s2_nrm.sign, exp_r, mant_sum[51:0]};
    end

    always_comb begin
        res_d = s2_raw;
        case (op_e'(s2_op))
            OP_PASS: res_d = s2_raw;
            OP_I2D:  res_d = i2d;
            OP_NEG:  res_d = {~s2_raw[63], s2_raw[62:0]};
            OP_ABS:  res_d = {1'b0, s2_raw[62:0]};
            default: res_d = s2_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data <= '0;
            s1_op   <= '0;
            s2_raw  <= '0;
            s2_op   <= '0;
            s2_nrm  <= '0;
            s3_res  <= '0;
        end else if (en) begin
            s1_data <= din;
            s1_op   <= op;
            s2_raw  <= s1_data;
            s2_op   <= s1_op;
            s2_nrm  <= nrm_d;
            s3_res  <= res_d;
        end
    end

    generate
        if (TAIL == 0) begin : g_no_tail
            assign dout = s3_res;
        end else begin : g_tail
            logic [63:0] tail_q [TAIL];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < TAIL; i++) tail_q[i] <= '0;
                end else if (en) begin
                    tail_q[0] <= s3_res;
                    for (int i = 1; i < TAIL; i++) tail_q[i] <= tail_q[i-1];
                end
            end

            assign dout = tail_q[TAIL-1];
        end
    endgenerate

endmodule

// File: rtl/pe_conv_lanes.sv
// rtl/pe_conv_lanes.sv - NUM_LANES converter lanes behind one valid/ready handshake
module pe_conv_lanes
    import pe_conv_lanes_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LATENCY   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_LANES*dwidth_double-1:0] inp,
    input  logic [1:0]                         op,
    input  logic                               t_valid_inp,
    output logic                               t_ready_inp,
    output logic [NUM_LANES*dwidth_double-1:0] out,
    output logic                               t_valid_out,
    input  logic                               t_ready_out,
    output logic [31:0]                        beat_count
);

    logic               advance;
    logic [LATENCY-1:0] valid_q;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign advance     = ~t_valid_out | t_ready_out;
    assign t_ready_inp = advance;
    assign t_valid_out = valid_q[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= {valid_q[LATENCY-2:0], t_valid_inp};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= 32'd0;
        end else if (t_valid_out && t_ready_out) begin
            beat_count <= beat_count + 32'd1;
        end
    end

    generate
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
            pe_i2d_lane #(
                .LATENCY(LATENCY)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .en   (advance),
                .din  (inp[dwidth_double*k +: dwidth_double]),
                .op   (op),
                .dout (out[dwidth_double*k +: dwidth_double])
            );
        end
    endgenerate

endmodule

// File: doc/pe_conv_lanes.md
PE_CONV_LANES -- requirements
Module: pe_conv_lanes

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of independent 64-bit data lanes sharing one handshake.
REQ-002 SHALL have parameter LATENCY, default 4, fixed input-to-output pipeline depth in enabled cycles; legal range 3..8.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port inp  input  NUM_LANES*dwidth_double  lane data, lane k at bits [64k+63:64k].
REQ-006 SHALL have port op  input  2  mode, sampled with each accepted beat: 00 pass, 01 int64->double, 10 negate double, 11 abs double.
REQ-007 SHALL have port t_valid_inp  input  1  input beat valid.
REQ-008 SHALL have port t_ready_inp  output  1  block can accept a beat this cycle.
REQ-009 SHALL have port out  output  NUM_LANES*dwidth_double  result data, same lane packing.
REQ-010 SHALL have port t_valid_out  output  1  output beat valid.
REQ-011 SHALL have port t_ready_out  input  1  downstream accepts the beat.
REQ-012 SHALL have port beat_count  output  32  count of output beats transferred since reset.

Function
REQ-013 SHALL define advance = ~t_valid_out | t_ready_out; t_ready_inp SHALL equal advance (combinational).
REQ-014 Input beat accepted iff t_valid_inp & t_ready_inp; output beat transferred iff t_valid_out & t_ready_out.
REQ-015 All pipeline stages (data, op, valid) SHALL shift only when advance=1 and hold otherwise; bubbles propagate as valid=0.
REQ-016 Beat accepted at enabled step n SHALL appear on out exactly LATENCY enabled steps later; with t_ready_out held 1, latency = LATENCY clk cycles.
REQ-017 Output order SHALL equal input order; every lane of a beat uses that beat's op; no two beats may collide at the output regardless of op mix.
REQ-018 op=00: out lane = inp lane bit-exact.
REQ-019 op=01: signed two's-complement int64 -> IEEE-754 binary64, round-to-nearest-even; 0 -> +0.0; INT64_MIN exact.
REQ-020 op=10: flip bit 63 only; op=11: clear bit 63 only; NaN/Inf/denormal payloads otherwise untouched.
REQ-021 t_valid_out, out SHALL be stable while t_valid_out=1 and t_ready_out=0.
REQ-022 beat_count SHALL increment by 1 per output transfer, wrap 0xFFFFFFFF -> 0.
REQ-023 Simultaneous accept and transfer in one cycle SHALL be supported at full throughput (one beat/cycle).

Reset
REQ-024 On rst=1 at a clock edge: all stage valids, t_valid_out and beat_count SHALL become 0; out SHALL become 0.
REQ-025 Beats in flight at reset SHALL be discarded and never emerge; t_ready_inp SHALL read 1 during and after reset.
REQ-026 First beat accepted after reset release SHALL behave per REQ-016.

Structure
REQ-027 dwidth_double (64), op encodings (OP_PASS, OP_I2D, OP_NEG, OP_ABS) and DBL_BIAS (1023) SHALL live in the shared package.
REQ-028 One sub-module pe_i2d_lane SHALL implement one lane: sign/magnitude, leading-zero count, normalise shift, RNE rounding with exponent carry, op mux, LATENCY-stage enable-gated pipeline; pe_conv_lanes instantiates NUM_LANES copies plus shared valid pipe, handshake and counter.

Verification
REQ-029 op=01, lanes {1, -2, 0, INT64_MIN}, ready=1 -> after 4 cycles out {0x3FF0000000000000, 0xC000000000000000, 0x0, 0xC3E0000000000000}.
REQ-030 op=01, lane 0x0020000000000001 (2^53+1) -> 0x4340000000000000; 0x0020000000000003 -> 0x4340000000000002 (ties-to-even).
REQ-031 Alternating op 00/01/10/11 beats back-to-back, ready=1 -> one output per cycle, in order; op=10 on 0x3FF0000000000000 -> 0xBFF0000000000000; op=11 on 0xC000000000000000 -> 0x4000000000000000.
REQ-032 Stream 10 beats, drop t_ready_out for 5 cycles mid-stream -> t_ready_inp=0 while stalled, out held stable, no loss/duplication, beat_count=10 at end.
REQ-033 Assert rst with 3 beats in flight -> no beat emerges, beat_count=0, next beat after release appears 4 cycles later.
REQ-034 Preload beat_count near wrap (force/long run) -> 0xFFFFFFFF then 0 on next transfer.
